// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: ISA widths, the canonical bubble and the IF/ID payload.
package pipeline_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instruction;
        logic            valid;
    } ifid_t;

endpackage

// File: rtl/ifid_reg.sv
// Generic pipeline register with hold and flush; flush replaces the masked bits with FLUSH_VAL.
module ifid_reg #(
    parameter int             W          = 97,
    parameter logic [W-1:0]   RST_VAL    = '0,
    parameter logic [W-1:0]   FLUSH_MASK = '0,
    parameter logic [W-1:0]   FLUSH_VAL  = '0
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         hold_i,
    input  logic         flush_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // Hold wins over flush; the owner decides when a redirect must override hold.
    always_comb begin
        data_d = d_i;
        if (hold_i) begin
            data_d = data_q;
        end else if (flush_i) begin
            data_d = (d_i & ~FLUSH_MASK) | (FLUSH_VAL & FLUSH_MASK);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, feeds instruction memory and fills the IF/ID register.
module if_stage
    import pipeline_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 64'h0,
    parameter logic [ILEN-1:0] NOP_INSTR  = pipeline_pkg::NOP_INSTR,
    parameter int unsigned     IMEM_BYTES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic [ILEN-1:0] Instruction,
    output logic [XLEN-1:0] Inst_Address,
    output logic [XLEN-1:0] ifid_pc,
    output logic [ILEN-1:0] ifid_instruction,
    output logic            ifid_valid,
    output logic            fetch_misaligned,
    output logic            pc_out_of_range,
    output logic [31:0]     fetch_count
);

    localparam ifid_t IFID_BUBBLE = '{pc: '0, instruction: NOP_INSTR, valid: 1'b0};
    localparam ifid_t IFID_MASK   = '{pc: '0, instruction: '1, valid: 1'b1};

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            misaligned_q;
    logic            misaligned_d;
    logic [31:0]     count_q;
    logic [31:0]     count_d;
    logic [XLEN:0]   pc_plus3;
    ifid_t           ifid_d;
    ifid_t           ifid_q;
    logic            ifid_hold;
    logic            ifid_flush;

    // Redirect beats stall beats flush; only a normal fetch retires an instruction.
    always_comb begin
        pc_d         = pc_q + 64'd4;
        misaligned_d = misaligned_q;
        count_d      = count_q;
        if (branch_taken) begin
            pc_d = {branch_target[XLEN-1:2], 2'b00};
            if (branch_target[1:0] != 2'b00) begin
                misaligned_d = 1'b1;
            end
        end else if (stall) begin
            pc_d = pc_q;
        end else if (!flush) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            misaligned_q <= 1'b0;
            count_q      <= '0;
        end else begin
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
            count_q      <= count_d;
        end
    end

    // A redirect squashes IF/ID even while the hazard unit is stalling.
    assign ifid_hold  = stall & ~branch_taken;
    assign ifid_flush = flush | branch_taken;
    assign ifid_d     = '{pc: pc_q, instruction: Instruction, valid: 1'b1};

    ifid_reg #(
        .W          ($bits(ifid_t)),
        .RST_VAL    (IFID_BUBBLE),
        .FLUSH_MASK (IFID_MASK),
        .FLUSH_VAL  (IFID_BUBBLE)
    ) u_ifid_reg (
        .clk_i   (clk),
        .reset_i (reset),
        .hold_i  (ifid_hold),
        .flush_i (ifid_flush),
        .d_i     (ifid_d),
        .q_o     (ifid_q)
    );

    assign pc_plus3 = {1'b0, pc_q} + (XLEN+1)'(3);

    assign Inst_Address     = pc_q;
    assign ifid_pc          = ifid_q.pc;
    assign ifid_instruction = ifid_q.instruction;
    assign ifid_valid       = ifid_q.valid;
    assign fetch_misaligned = misaligned_q;
    assign fetch_count      = count_q;
    assign pc_out_of_range  = (pc_plus3 >= (XLEN+1)'(IMEM_BYTES));

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: stimulus pushes expected post-edge state, a monitor compares it.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [63:0] branch_target = '0;
    logic [31:0] Instruction;
    logic [63:0] Inst_Address;
    logic [63:0] ifid_pc;
    logic [31:0] ifid_instruction;
    logic        ifid_valid;
    logic        fetch_misaligned;
    logic        pc_out_of_range;
    logic [31:0] fetch_count;

    logic [31:0] imem [64];

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] ipc;
        logic [31:0] ins;
        logic        v;
        logic        mis;
        logic        oor;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    // Reference state: what the fetch stage should hold after each edge.
    logic [63:0] m_pc;
    logic [63:0] m_ipc;
    logic [31:0] m_ins;
    logic        m_v;
    logic        m_mis;
    logic [31:0] m_cnt;

    if_stage dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .flush            (flush),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .Instruction      (Instruction),
        .Inst_Address     (Inst_Address),
        .ifid_pc          (ifid_pc),
        .ifid_instruction (ifid_instruction),
        .ifid_valid       (ifid_valid),
        .fetch_misaligned (fetch_misaligned),
        .pc_out_of_range  (pc_out_of_range),
        .fetch_count      (fetch_count)
    );

    always #5 clk = ~clk;

    assign Instruction = imem[Inst_Address[7:2]];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] addr);
        logic [5:0] idx;
        idx = addr[7:2];
        return imem[idx];
    endfunction

    task automatic model_reset();
        m_pc  = 64'h0;
        m_ipc = 64'h0;
        m_ins = NOP;
        m_v   = 1'b0;
        m_mis = 1'b0;
        m_cnt = 32'd0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_addr"},  Inst_Address, 64'h0);
        chk({tag, "_ipc"},   ifid_pc, 64'h0);
        chk({tag, "_ins"},   {32'h0, ifid_instruction}, {32'h0, NOP});
        chk({tag, "_valid"}, {63'h0, ifid_valid}, 64'h0);
        chk({tag, "_mis"},   {63'h0, fetch_misaligned}, 64'h0);
        chk({tag, "_cnt"},   {32'h0, fetch_count}, 64'h0);
    endtask

    // Drive one cycle of controls, predict the state after the next edge, then wait past it.
    task automatic step(input logic b, input logic s, input logic f, input logic [63:0] tgt);
        exp_t e;
        branch_taken  = b;
        stall         = s;
        flush         = f;
        branch_target = tgt;
        if (b) begin
            m_ipc = m_pc;
            m_ins = NOP;
            m_v   = 1'b0;
            if (tgt % 4 != 0) m_mis = 1'b1;
            m_pc = tgt - (tgt % 4);
        end else if (!s) begin
            m_ipc = m_pc;
            if (f) begin
                m_ins = NOP;
                m_v   = 1'b0;
            end else begin
                m_ins = mem_word(m_pc);
                m_v   = 1'b1;
                m_cnt = m_cnt + 1;
            end
            m_pc = m_pc + 4;
        end
        e.pc  = m_pc;
        e.ipc = m_ipc;
        e.ins = m_ins;
        e.v   = m_v;
        e.mis = m_mis;
        e.oor = (m_pc >= 64'd13);
        e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("pc",        Inst_Address, e.pc);
            chk("ifid_pc",   ifid_pc, e.ipc);
            chk("ifid_ins",  {32'h0, ifid_instruction}, {32'h0, e.ins});
            chk("ifid_vld",  {63'h0, ifid_valid}, {63'h0, e.v});
            chk("misalign",  {63'h0, fetch_misaligned}, {63'h0, e.mis});
            chk("oor",       {63'h0, pc_out_of_range}, {63'h0, e.oor});
            chk("count",     {32'h0, fetch_count}, {32'h0, e.cnt});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = $urandom;
        imem[0] = 32'h1000_0513;
        imem[1] = 32'h0050_0293;
        imem[2] = 32'h0000_0b13;
        imem[6] = 32'h045b_0463;
        model_reset();

        #7;
        check_reset_values("rst_hold");
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("first_addr", Inst_Address, 64'h0);

        // Free-running fetch from address 0.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("ins_second", {32'h0, ifid_instruction}, 64'h0050_0293);
        chk("cnt_second", {32'h0, fetch_count}, 64'd2);

        // Stall at pc=8, then release.
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("stall_addr", Inst_Address, 64'h8);
        step(0, 0, 0, 0);
        chk("after_stall_ins", {32'h0, ifid_instruction}, 64'h0000_0b13);

        // Redirect wins over a simultaneous stall.
        step(1, 1, 0, 64'h18);
        chk("redir_addr", Inst_Address, 64'h18);
        step(0, 0, 0, 0);
        chk("redir_ins", {32'h0, ifid_instruction}, 64'h045b_0463);

        // Flush at pc=0xC.
        step(1, 0, 0, 64'hC);
        step(0, 0, 1, 0);
        chk("flush_addr", Inst_Address, 64'h10);

        // Misaligned redirect, stays sticky across normal fetches.
        step(1, 0, 0, 64'h1A);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("mis_sticky", {63'h0, fetch_misaligned}, 64'h1);

        // Asynchronous reset between edges at pc=0x14.
        step(1, 0, 0, 64'h14);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("async_rst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        branch_taken = 1'b0;

        // 64-bit PC wrap.
        step(1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC);
        step(0, 0, 0, 0);
        chk("wrap_addr", Inst_Address, 64'h0);

        // Randomized control mix.
        for (int i = 0; i < 400; i++) begin
            logic        b, s, f;
            logic [63:0] tgt;
            b = ($urandom_range(0, 99) < 12);
            s = ($urandom_range(0, 99) < 20);
            f = ($urandom_range(0, 99) < 15);
            if ($urandom_range(0, 9) == 0)
                tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
            else if ($urandom_range(0, 9) == 0)
                tgt = 64'($urandom_range(0, 255));
            else
                tgt = 64'($urandom_range(0, 63)) * 4;
            step(b, s, f, tgt);
        end

        // Final reset clears the sticky flag.
        reset = 1'b1;
        #1;
        check_reset_values("final_rst");
        #20;
        chk("sb_drain", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline, directly upstream of Instruction_Memory.
- Owns the program counter and drives Inst_Address to Instruction_Memory.
- Takes back the 32-bit Instruction and captures PC/instruction into the IF/ID pipeline register for decode.
- Handles hazard-unit stalls, branch/jump redirects and flushes, and keeps a retired-fetch counter for debug.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, bubble (addi x0,x0,0) inserted into IF/ID on flush/redirect.
- IMEM_BYTES, 16, instruction-memory size in bytes; used for the out-of-range flag.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hazard unit: hold PC and IF/ID.
- flush  input  1  squash IF/ID contents (insert bubble); PC still advances normally.
- branch_taken  input  1  redirect request from EX/MEM.
- branch_target  input  64  redirect PC.
- Instruction  input  32  fetched word from Instruction_Memory (combinational from Inst_Address).
- Inst_Address  output  64  current PC to Instruction_Memory (= pc register, combinational).
- ifid_pc  output  64  PC of instruction held in IF/ID.
- ifid_instruction  output  32  instruction held in IF/ID.
- ifid_valid  output  1  IF/ID holds a real instruction.
- fetch_misaligned  output  1  sticky: a redirect target had [1:0]!=0.
- pc_out_of_range  output  1  combinational: pc+3 >= IMEM_BYTES.
- fetch_count  output  32  number of instructions accepted into IF/ID with valid=1.

Behaviour:
- Reset (async, any time incl. mid-redirect):
  - pc=RESET_PC, ifid_pc=0, ifid_instruction=NOP_INSTR, ifid_valid=0.
  - fetch_misaligned=0, fetch_count=0.
  - First rising edge after reset deasserts captures the word at RESET_PC.
- Inst_Address = pc, no latency; Instruction is sampled in the same cycle.
- Per-edge priority, highest first: branch_taken > stall > flush > normal.
  - branch_taken=1 (regardless of stall/flush):
    - pc <= {branch_target[63:2],2'b00}.
    - IF/ID <= {pc, NOP_INSTR, valid=0}.
    - If branch_target[1:0]!=0, fetch_misaligned <= 1 (sticky until reset).
  - stall=1, no redirect: pc, IF/ID and fetch_count hold.
  - flush=1, no stall/redirect: pc <= pc+4; IF/ID <= {pc, NOP_INSTR, 0}.
  - Normal: pc <= pc+4; IF/ID <= {pc, Instruction, 1}; fetch_count <= fetch_count+1.
- fetch_count increments only on the normal path; wraps modulo 2^32.
- pc+4 arithmetic is 64-bit, wraps modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC -> 0).
- pc_out_of_range is informational only and does not stop fetch.
- Redirect latency: target appears on Inst_Address one cycle after the branch_taken edge. The instruction at the target is valid in IF/ID two edges after branch_taken.

Decomposition:
- Shared package pipeline_pkg:
  - NOP_INSTR constant.
  - XLEN=64 and ILEN=32 constants.
  - ifid_t struct {pc, instruction, valid}, reused by the ID stage.
- Natural sub-module: ifid_reg, the IF/ID register with hold/flush controls and async reset. It is reused by the ID/EX and EX/MEM registers with different widths.
- PC logic and counter stay in if_stage.

Test Plan:
- Reset release, RESET_PC=0, imem = {0x10000513, 0x00500293, 0x00000b13, ...}, 3 free-running cycles:
  - Inst_Address 0,4,8.
  - ifid_instruction 0x10000513 then 0x00500293, ifid_valid=1.
  - fetch_count=2 after 2nd edge.
- stall held 2 cycles at pc=8:
  - Inst_Address stays 8; IF/ID and fetch_count unchanged.
  - On release the next edge loads 0x00000b13 with ifid_pc=8.
- branch_taken=1, target=0x18, asserted together with stall=1:
  - Next edge pc=0x18, ifid_valid=0, ifid_instruction=0x00000013.
  - Following edge ifid_instruction=0x045b0463, ifid_pc=0x18.
- flush=1 for one cycle at pc=0xC:
  - pc -> 0x10, IF/ID bubble, fetch_count unchanged.
- Redirect to 0x1A:
  - pc=0x18 and fetch_misaligned=1.
  - fetch_misaligned remains 1 after further normal fetches until reset.
- Async reset mid-stream at pc=0x14, asserted between clock edges:
  - All outputs go to reset values immediately, without waiting for a clock edge.
  - Separately, force pc=0xFFFF_FFFF_FFFF_FFFC: one normal edge wraps pc to 0.
